// File: rtl/button_deb_sched.sv
// Debounces NB_BUTTONS push-buttons that share one debounce timer.
// A round-robin arbiter hands the timer to a button whose synchronized level differs from its debounced level.
module button_deb_sched #(
  parameter int NB_BUTTONS      = 4,
  parameter int CLK_FREQ        = 95000,
  parameter int DEBOUNCE_PER_MS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NB_BUTTONS-1:0] button_in,
  output logic [NB_BUTTONS-1:0] button_state,
  output logic [NB_BUTTONS-1:0] button_press,
  output logic [NB_BUTTONS-1:0] button_release,
  output logic                  busy,
  output logic [((NB_BUTTONS > 1) ? $clog2(NB_BUTTONS) : 1)-1:0] grant_id
);

  localparam int PERIOD = CLK_FREQ * DEBOUNCE_PER_MS;
  localparam int CW     = $clog2(PERIOD + 1);
  localparam int GW     = (NB_BUTTONS > 1) ? $clog2(NB_BUTTONS) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic [GW-1:0]         last_grant;
  logic [NB_BUTTONS-1:0] btn_meta;
  logic [NB_BUTTONS-1:0] btn_s;
  logic [NB_BUTTONS-1:0] req;

  // Round-robin search: rotate the request vector so the bit after last_grant sits at position 0.
  logic [GW-1:0]           start;
  logic [2*NB_BUTTONS-1:0] req2;
  logic [NB_BUTTONS-1:0]   rot;
  logic [GW-1:0]           offset;
  logic [GW:0]             sum;
  logic [GW-1:0]           pick;

  assign req  = btn_s ^ button_state;
  assign req2 = {req, req};

  always_comb begin
    start = (last_grant == GW'(NB_BUTTONS - 1)) ? '0 : last_grant + 1'b1;
    rot   = NB_BUTTONS'(req2 >> start);
    offset = '0;
    for (int i = NB_BUTTONS - 1; i >= 0; i--) begin
      if (rot[i]) offset = GW'(i);
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= (GW + 1)'(NB_BUTTONS)) sum = sum - (GW + 1)'(NB_BUTTONS);
    pick = GW'(sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta       <= '0;
      btn_s          <= '0;
      button_state   <= '0;
      button_press   <= '0;
      button_release <= '0;
      busy           <= 1'b0;
      grant_id       <= '0;
      count          <= '0;
      last_grant     <= GW'(NB_BUTTONS - 1);
      state          <= IDLE;
    end else begin
      btn_meta       <= button_in;
      btn_s          <= btn_meta;
      button_press   <= '0;
      button_release <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_id <= pick;
            count    <= '0;
            busy     <= 1'b1;
            state    <= COUNT;
          end
        end
        COUNT: begin
          // The granted button bounced back to its committed level: drop it silently.
          if (btn_s[grant_id] == button_state[grant_id]) begin
            last_grant <= grant_id;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (count == CW'(PERIOD - 1)) begin
            state <= COMMIT;
          end else begin
            count <= count + 1'b1;
          end
        end
        COMMIT: begin
          button_state[grant_id] <= ~button_state[grant_id];
          if (!button_state[grant_id]) button_press[grant_id]   <= 1'b1;
          else                         button_release[grant_id] <= 1'b1;
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_deb_sched.sv
// Bench for button_deb_sched: timestamp-based reference model checked every cycle,
// directed scenarios with literal latencies, then randomized button activity with random resets.
module tb_button_deb_sched;

  localparam int N = 4;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] button_in = '0;
  logic [3:0] button_state, button_press, button_release;
  logic       busy;
  logic [1:0] grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_deb_sched #(
    .NB_BUTTONS(N), .CLK_FREQ(1), .DEBOUNCE_PER_MS(P)
  ) dut (
    .clk(clk), .rst(rst), .button_in(button_in),
    .button_state(button_state), .button_press(button_press),
    .button_release(button_release), .busy(busy), .grant_id(grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the timer owner is remembered with the cycle it was granted in.
  // It must differ from its committed level on each of the next P cycles; the cycle after that commits.
  logic [3:0] m_s1 = '0, m_s2 = '0, m_state = '0, m_press = '0, m_rel = '0;
  logic [1:0] m_gid = '0;
  logic [3:0] m_req;
  int         m_owner = -1, m_t0 = 0, m_last = N - 1, m_cyc = 0, m_k, m_c;
  bit         m_found;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_state = '0; m_press = '0; m_rel = '0;
      m_gid = '0; m_owner = -1; m_last = N - 1;
    end else begin
      m_cyc++;
      m_req   = m_s2 ^ m_state;
      m_press = '0;
      m_rel   = '0;
      if (m_owner < 0) begin
        m_found = 1'b0;
        for (int i = 1; i <= N; i++) begin
          m_c = (m_last + i) % N;
          if (!m_found && m_req[m_c]) begin
            m_found = 1'b1;
            m_owner = m_c;
            m_gid   = 2'(m_c);
            m_t0    = m_cyc;
          end
        end
      end else begin
        m_k = m_cyc - m_t0;
        if (m_k <= P) begin
          if (m_s2[m_owner] == m_state[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
          end
        end else begin
          m_state[m_owner] = ~m_state[m_owner];
          if (m_state[m_owner]) m_press[m_owner] = 1'b1;
          else                  m_rel[m_owner]   = 1'b1;
          m_last  = m_owner;
          m_owner = -1;
        end
      end
      m_s2 = m_s1;
      m_s1 = button_in;
    end
  end

  always @(negedge clk) begin
    check("state",    32'(button_state),   32'(m_state));
    check("press",    32'(button_press),   32'(m_press));
    check("release",  32'(button_release), 32'(m_rel));
    check("busy",     32'(busy),           32'(m_owner >= 0));
    check("grant_id", 32'(grant_id),       32'(m_gid));
  end

  // Counts negedges from k0; returns the first cycle carrying a pulse, or -1 when kmax is reached.
  task automatic wait_event(input int k0, input int kmax, output int k,
                            output logic [3:0] p, output logic [3:0] r);
    k = k0; p = '0; r = '0;
    while (k < kmax) begin
      @(negedge clk);
      k++;
      if ((button_press | button_release) != 4'b0) begin
        p = button_press;
        r = button_release;
        return;
      end
    end
    k = -1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int         k;
  logic [3:0] p, r;
  bit         seen_busy, seen_ev, g0, g1, p1, e0, prev_busy;
  int         rst_hold;

  initial begin
    // 1: reset with random inputs
    repeat (5) begin
      @(negedge clk);
      button_in = 4'($urandom_range(0, 15));
    end
    check("rst_state", 32'(button_state), 0);
    check("rst_pulses", 32'(button_press | button_release), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 0);
    @(negedge clk);
    button_in = '0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_state", 32'(button_state), 0);

    // 2: single press then release on button 2
    button_in = 4'b0100;
    wait_event(0, 20, k, p, r);
    check("t2_press_edge", 32'(k), 8);
    check("t2_press_mask", 32'(p), 32'h4);
    check("t2_grant", 32'(grant_id), 2);
    check("t2_state", 32'(button_state), 32'h4);
    @(negedge clk);
    check("t2_pulse_width", 32'(button_press), 0);
    button_in = 4'b0000;
    wait_event(0, 20, k, p, r);
    check("t2_release_edge", 32'(k), 8);
    check("t2_release_mask", 32'(r), 32'h4);
    check("t2_state_after", 32'(button_state), 0);
    repeat (4) @(negedge clk);

    // 3: short glitch on button 0 is aborted
    button_in = 4'b0001;
    seen_busy = 0; seen_ev = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 2) button_in = 4'b0000;
      seen_busy |= busy;
      seen_ev   |= ((button_press | button_release) != 4'b0);
    end
    check("t3_busy_seen", 32'(seen_busy), 1);
    check("t3_no_event", 32'(seen_ev), 0);
    check("t3_state", 32'(button_state), 0);

    // 4: simultaneous rise on buttons 0 and 3 from a fresh arbiter
    pulse_reset();
    button_in = 4'b1001;
    wait_event(0, 30, k, p, r);
    check("t4_first_edge", 32'(k), 8);
    check("t4_first_mask", 32'(p), 32'h1);
    wait_event(k, 30, k, p, r);
    check("t4_second_edge", 32'(k), 14);
    check("t4_second_mask", 32'(p), 32'h8);
    button_in = 4'b0000;
    repeat (20) @(negedge clk);
    check("t4_released", 32'(button_state), 0);

    // 5: button 0 bounces continuously while button 1 is held
    button_in = 4'b0011;
    g0 = 0; g1 = 0; p1 = 0; e0 = 0; prev_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 2 == 1) button_in[0] = ~button_in[0];
      if (busy && !prev_busy) begin
        if (grant_id == 2'd0) g0 = 1;
        if (grant_id == 2'd1) g1 = 1;
      end
      prev_busy = busy;
      if (button_press[1]) p1 = 1;
      if (button_press[0] | button_release[0]) e0 = 1;
    end
    check("t5_grant0", 32'(g0), 1);
    check("t5_grant1", 32'(g1), 1);
    check("t5_press1", 32'(p1), 1);
    check("t5_no_event0", 32'(e0), 0);
    button_in = 4'b0000;
    repeat (20) @(negedge clk);

    // 6: reset in the middle of timing button 1
    button_in = 4'b0010;
    repeat (5) @(negedge clk);
    check("t6_busy_before", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_state", 32'(button_state), 0);
    check("t6_rst_pulses", 32'(button_press | button_release), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_event(0, 20, k, p, r);
    check("t6_redeb_edge", 32'(k), 8);
    check("t6_redeb_mask", 32'(p), 32'h2);

    // Random activity: slow and fast toggling segments, occasional resets
    rst_hold = 0;
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 700; i++) begin
        @(negedge clk);
        if (rst_hold > 0) begin
          rst_hold--;
          if (rst_hold == 0) rst = 1'b0;
        end
        for (int b = 0; b < N; b++) begin
          if ($urandom_range(0, (seg % 2 == 0) ? 15 : 2) == 0) button_in[b] = ~button_in[b];
        end
        if (rst_hold == 0 && $urandom_range(0, 399) == 0) begin
          rst_hold = 2;
          #2 rst = 1'b1;
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
